sw_change_encoder: RTL
======================

Name: sw_change_encoder

Overview:
- Upstream front end for the memory-game core.
- Watches the 10 player slide switches, synchronises and debounces each one, and encodes a confirmed toggle as a 4-bit switch index on `change`.
- `change` reads 4'hF (IDLE_CODE) when no toggle is being reported.
- Each code is held long enough for the core's slow action tick to sample it exactly once. The core has no acknowledge, so the hold time is the only handshake.

Parameters:
- NUM_SW, 10, number of switches; indices 0..NUM_SW-1, must be ≤ 15.
- DEBOUNCE_CYCLES, 20, consecutive cycles a synchronised switch must differ from its stable value before a toggle is confirmed.
- HOLD_CYCLES, 1001, cycles a code stays on `change`; equals the core's action-tick period (counter_max+1).
- IDLE_CODE, 4'hF, value of `change` when nothing is reported.

Ports:
- clk, input, 1, system clock.
- reset, input, 1, synchronous active-high reset.
- sw, input, NUM_SW, raw asynchronous switch levels.
- enable, input, 1, high while the core is in its input phase; low discards events.
- change, output, 4, held switch index or IDLE_CODE.
- change_valid, output, 1, high exactly when change != IDLE_CODE.
- multi_err, output, 1, one-cycle pulse when more than one switch confirms in the same cycle.
- overflow, output, 1, sticky; set when a confirmed toggle is dropped because the pending slot is full.

Behaviour:
Clock and reset:
- One clock, `clk`.
- Reset is synchronous and active-high on `reset`; it has priority over all other logic.
- Reset values: change=IDLE_CODE, change_valid=0, multi_err=0, overflow=0, hold counter=0, pending empty.
- On reset, both synchroniser stages and every stable register load the current raw `sw`, so switches already up produce no event.
- All debounce counters reset to 0.

Per switch (sub-module):
- 2-flop synchroniser produces sw_s.
- Each cycle sw_s != stable: cnt increments.
- Any cycle sw_s == stable: cnt clears to 0.
- When cnt == DEBOUNCE_CYCLES-1 and sw_s still != stable: stable <= sw_s, cnt <= 0, and a registered `toggle` pulse is high for one cycle.
- Both up and down transitions count as toggles.

Latency:
- First clock edge that samples a new `sw` level = edge 0.
- `change` shows the index at edge DEBOUNCE_CYCLES+3, with no variation allowed.
- Bounce shorter than DEBOUNCE_CYCLES synchronised cycles produces no event.

Encoder and arbitration:
- Lowest set toggle bit wins.
- If ≥2 toggle bits are set in one cycle: multi_err pulses 1 cycle and the losing indices are dropped. Dropped losers do not set overflow.

Output state machine (states IDLE, HOLD):
- IDLE, event arrives: change <= index, hold counter <= HOLD_CYCLES-1, go to HOLD.
- HOLD, counter > 0: decrement each cycle.
  - A new event goes into the 1-deep pending slot if it is empty.
  - If the slot is full, the event is dropped and overflow <= 1.
- HOLD, counter == 0 with pending valid: load pending into change, reload counter, stay in HOLD. There is no idle gap between codes.
- HOLD, counter == 0 with pending empty and a new event in the same cycle: the event goes directly to change and the counter reloads.
- HOLD, counter == 0 with nothing: change <= IDLE_CODE, go to IDLE.

Each code is therefore driven for exactly HOLD_CYCLES cycles.

Enable:
- While enable=0: change forced to IDLE_CODE, state IDLE, pending cleared.
- Events are discarded and do not set overflow. multi_err is still reported.
- Debouncers keep tracking.
- enable falling mid-HOLD aborts the code on the next edge.

Reset mid-operation returns everything to reset values, including clearing the sticky overflow.

Decomposition:
- Shared package `game_pkg`:
  - IDLE_CODE=4'hF.
  - SW_IDX_W=4.
  - NUM_SW=10.
  - ACTION_PERIOD=1001, from which HOLD_CYCLES defaults.
  - A typedef for the output state enum (IDLE, HOLD).
- One sub-module, `sw_debounce`: a single switch with synchroniser, counter, stable register and toggle pulse. It is instantiated NUM_SW times in a generate loop.
- Encoder, pending slot and hold FSM live in the top level.

Test Plan (DEBOUNCE_CYCLES=4, HOLD_CYCLES=8 unless noted):
1. Reset with sw=10'b0000000100, then hold sw constant 50 cycles -> change=4'hF and change_valid=0 throughout; no events.
2. Raise sw[3] cleanly after reset, enable=1 -> change=4'd3 at edge 7, held exactly 8 cycles, then 4'hF; change_valid mirrors it.
3. Toggle sw[5] high for 2 cycles then back low (bounce) -> no event. Then hold sw[5] high -> exactly one code 4'd5.
4. Raise sw[2] and sw[7] on the same edge -> change=4'd2, multi_err one 1-cycle pulse, no code 7, overflow=0.
5. Toggle sw[1], then sw[4] 3 cycles later, then sw[6] 2 cycles after that -> codes 1 then 4 back-to-back with 8 cycles each. sw[6] dropped, overflow=1 and stays 1 until reset.
6. Drop enable to 0 mid-HOLD of code 9 -> change=4'hF next edge. Toggle sw[0] while disabled -> nothing reported and overflow unchanged. Assert reset -> all outputs return to reset values.

Source files
------------

// File: rtl/game_pkg.sv
// Shared constants and types for the memory-game front end.
//   IDLE_CODE     : value on `change` when no switch index is being reported
//   SW_IDX_W      : width of a switch index
//   NUM_SW        : number of player slide switches
//   ACTION_PERIOD : core action-tick period in clk cycles (counter_max + 1)
//   out_state_t   : output hold state machine encoding
package game_pkg;

   localparam int                  SW_IDX_W      = 4;
   localparam logic [SW_IDX_W-1:0] IDLE_CODE     = 4'hF;
   localparam int                  NUM_SW        = 10;
   localparam int                  ACTION_PERIOD = 1001;

   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } out_state_t;

endpackage

// File: rtl/sw_debounce.sv
// One slide switch: 2-flop synchroniser, debounce counter, stable level and
// a one-cycle registered toggle pulse on every confirmed up or down change.
//   clk    : system clock
//   reset  : synchronous active-high reset; loads the raw level everywhere so
//            a switch already up at reset produces no toggle
//   sw     : raw asynchronous switch level
//   toggle : one-cycle pulse when a new level has been confirmed
module sw_debounce #(
   parameter int DEBOUNCE_CYCLES = 20
) (
   input  logic clk,
   input  logic reset,
   input  logic sw,
   output logic toggle
);

   localparam int               CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sw_m;
   logic             sw_s;
   logic             stable;
   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         sw_m   <= sw;
         sw_s   <= sw;
         stable <= sw;
         cnt    <= '0;
         toggle <= 1'b0;
      end else begin
         sw_m   <= sw;
         sw_s   <= sw_m;
         toggle <= 1'b0;
         // Any agreeing sample restarts the count, so only an unbroken run of
         // DEBOUNCE_CYCLES differing samples confirms the new level.
         if (sw_s == stable) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            stable <= sw_s;
            cnt    <= '0;
            toggle <= 1'b1;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/sw_change_encoder.sv
// Front end for the memory-game core: debounces the player switches and
// reports each confirmed toggle as a switch index held on `change` for one
// full action-tick period, so the core samples it exactly once.
//   clk          : system clock
//   reset        : synchronous active-high reset, highest priority
//   sw           : raw switch levels
//   enable       : core input phase; low discards events and clears output
//   change       : held switch index, or IDLE_CODE
//   change_valid : high exactly when change != IDLE_CODE
//   multi_err    : one-cycle pulse when several switches confirm together
//   overflow     : sticky; a toggle was lost because the pending slot was full
//
// state | meaning
// IDLE  | change = IDLE_CODE, waiting for an event
// HOLD  | change holds an index; hold_cnt counts down to the next code/idle
module sw_change_encoder
   import game_pkg::*;
#(
   parameter int NUM_SW          = game_pkg::NUM_SW,
   parameter int DEBOUNCE_CYCLES = 20,
   parameter int HOLD_CYCLES     = ACTION_PERIOD
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [NUM_SW-1:0]   sw,
   input  logic                enable,
   output logic [SW_IDX_W-1:0] change,
   output logic                change_valid,
   output logic                multi_err,
   output logic                overflow
);

   localparam int                HOLD_W    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);

   logic [NUM_SW-1:0] toggle;

   for (genvar i = 0; i < NUM_SW; i++) begin : g_sw
      sw_debounce #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_debounce (
         .clk    (clk),
         .reset  (reset),
         .sw     (sw[i]),
         .toggle (toggle[i])
      );
   end

   // Lowest index wins: scanning downward lets the lowest set bit overwrite.
   logic [SW_IDX_W-1:0] enc_idx;
   logic                enc_any;
   logic                enc_multi;

   always_comb begin
      enc_idx = IDLE_CODE;
      for (int i = NUM_SW - 1; i >= 0; i--) begin
         if (toggle[i]) enc_idx = SW_IDX_W'(i);
      end
      enc_any   = |toggle;
      enc_multi = ($countones(toggle) > 1);
   end

   // Encoder register: sets the fixed DEBOUNCE_CYCLES+3 latency to `change`.
   logic                ev_valid;
   logic [SW_IDX_W-1:0] ev_idx;

   always_ff @(posedge clk) begin
      if (reset) begin
         ev_valid  <= 1'b0;
         ev_idx    <= IDLE_CODE;
         multi_err <= 1'b0;
      end else begin
         ev_valid  <= enc_any;
         ev_idx    <= enc_idx;
         multi_err <= enc_multi;
      end
   end

   out_state_t          state,      state_nxt;
   logic [SW_IDX_W-1:0] change_nxt;
   logic [HOLD_W-1:0]   hold_cnt,   hold_nxt;
   logic                pend_valid, pend_valid_nxt;
   logic [SW_IDX_W-1:0] pend_idx,   pend_idx_nxt;
   logic                overflow_nxt;

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         change     <= IDLE_CODE;
         hold_cnt   <= '0;
         pend_valid <= 1'b0;
         pend_idx   <= IDLE_CODE;
         overflow   <= 1'b0;
      end else begin
         state      <= state_nxt;
         change     <= change_nxt;
         hold_cnt   <= hold_nxt;
         pend_valid <= pend_valid_nxt;
         pend_idx   <= pend_idx_nxt;
         overflow   <= overflow_nxt;
      end
   end

   always_comb begin
      state_nxt      = state;
      change_nxt     = change;
      hold_nxt       = hold_cnt;
      pend_valid_nxt = pend_valid;
      pend_idx_nxt   = pend_idx;
      overflow_nxt   = overflow;

      if (!enable) begin
         state_nxt      = IDLE;
         change_nxt     = IDLE_CODE;
         hold_nxt       = '0;
         pend_valid_nxt = 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (ev_valid) begin
                  change_nxt = ev_idx;
                  hold_nxt   = HOLD_LOAD;
                  state_nxt  = HOLD;
               end
            end
            HOLD: begin
               if (hold_cnt != '0) begin
                  hold_nxt = hold_cnt - 1'b1;
                  if (ev_valid) begin
                     if (!pend_valid) begin
                        pend_valid_nxt = 1'b1;
                        pend_idx_nxt   = ev_idx;
                     end else begin
                        overflow_nxt = 1'b1;
                     end
                  end
               end else if (pend_valid) begin
                  // Pending code follows with no idle gap; the slot it frees
                  // can take an event arriving on this same cycle.
                  change_nxt     = pend_idx;
                  hold_nxt       = HOLD_LOAD;
                  pend_valid_nxt = ev_valid;
                  if (ev_valid) pend_idx_nxt = ev_idx;
               end else if (ev_valid) begin
                  change_nxt = ev_idx;
                  hold_nxt   = HOLD_LOAD;
               end else begin
                  change_nxt = IDLE_CODE;
                  state_nxt  = IDLE;
               end
            end
            default: begin
               state_nxt  = IDLE;
               change_nxt = IDLE_CODE;
            end
         endcase
      end
   end

   assign change_valid = (change != IDLE_CODE);

endmodule
